// File: rtl/pic_rw_ctrl_buffer.sv
// pic_rw_ctrl_buffer
//   Host-side front end of the interrupt controller. It decodes CPU bus
//   cycles into one-cycle write events and classifies each write as an
//   ICW or OCW through the initialization-sequence state machine. It also
//   gates core read data onto the bidirectional system bus.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   CSn, rdn, wrn   active-low chip select, read strobe and write strobe
//   A0              register address bit
//   D[7:0]          system data bus (inout)
//   PCadr[7:0]      core read data driven onto D when en & ino
//   en, ino         buffer enable and direction (1 = drive D)
//   WR[7:0]         data of the last completed write
//   cadr[2:0]       code of the last write: 0 none, 1-4 ICW1-4, 5-7 OCW1-3
//   b0              A0 of the last completed write
//   wrflg           one-cycle pulse per completed write
//   rdflag          registered read-cycle indicator
//
// Configuration
//   PIC_RW_ICW4_EN  when defined, IC4 from ICW1 is honoured and ICW4 can be
//                   reported. When undefined, IC4 is forced to 0 and the
//                   sequence ends after ICW2 or ICW3.

module pic_rw_ctrl_buffer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       CSn,
    input  logic       rdn,
    input  logic       wrn,
    input  logic       A0,
    inout  wire  [7:0] D,
    input  logic [7:0] PCadr,
    input  logic       en,
    input  logic       ino,
    output logic [7:0] WR,
    output logic [2:0] cadr,
    output logic       b0,
    output logic       wrflg,
    output logic       rdflag
);

    typedef enum logic [2:0] {
        WAIT_ICW1 = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_e;

    localparam logic [2:0] C_NONE = 3'd0;
    localparam logic [2:0] C_ICW1 = 3'd1;
    localparam logic [2:0] C_ICW2 = 3'd2;
    localparam logic [2:0] C_ICW3 = 3'd3;
    localparam logic [2:0] C_ICW4 = 3'd4;
    localparam logic [2:0] C_OCW1 = 3'd5;
    localparam logic [2:0] C_OCW2 = 3'd6;
    localparam logic [2:0] C_OCW3 = 3'd7;

    // Bus buffer: purely combinational
    assign D = (en && ino) ? PCadr : 8'hzz;

    logic       rd_act, wr_act, wr_done;
    logic       wr_act_q;
    logic [7:0] sh_d_q;
    logic       sh_a0_q;
    state_e     state_q, state_d;
    logic       sngl_q, sngl_d;
    logic       ic4_q, ic4_d;
    logic [2:0] code;
    logic [7:0] wr_q;
    logic [2:0] cadr_q;
    logic       b0_q, wrflg_q, rdflag_q;

    // Both strobes low at once counts as neither a read nor a write, so an
    // in-progress write completes when rdn drops.
    assign rd_act  = !CSn && !rdn &&  wrn;
    assign wr_act  = !CSn && !wrn &&  rdn;
    assign wr_done = wr_act_q && !wr_act;

    // Decode of the shadowed write against the current init state
    always_comb begin
        state_d = state_q;
        sngl_d  = sngl_q;
        ic4_d   = ic4_q;
        code    = C_NONE;
        if (!sh_a0_q && sh_d_q[4]) begin
            code    = C_ICW1;
            state_d = WAIT_ICW2;
            sngl_d  = sh_d_q[1];
`ifdef PIC_RW_ICW4_EN
            ic4_d   = sh_d_q[0];
`else
            ic4_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                WAIT_ICW2: if (sh_a0_q) begin
                    code = C_ICW2;
                    if (!sngl_q)    state_d = WAIT_ICW3;
                    else if (ic4_q) state_d = WAIT_ICW4;
                    else            state_d = READY;
                end
                WAIT_ICW3: if (sh_a0_q) begin
                    code    = C_ICW3;
                    state_d = ic4_q ? WAIT_ICW4 : READY;
                end
                WAIT_ICW4: if (sh_a0_q) begin
                    code    = C_ICW4;
                    state_d = READY;
                end
                READY: begin
                    if (sh_a0_q)                   code = C_OCW1;
                    else if (sh_d_q[4:3] == 2'b00) code = C_OCW2;
                    else if (sh_d_q[4:3] == 2'b01) code = C_OCW3;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_act_q <= 1'b0;
            sh_d_q   <= 8'h00;
            sh_a0_q  <= 1'b0;
            state_q  <= WAIT_ICW1;
            sngl_q   <= 1'b0;
            ic4_q    <= 1'b0;
            wr_q     <= 8'h00;
            cadr_q   <= C_NONE;
            b0_q     <= 1'b0;
            wrflg_q  <= 1'b0;
            rdflag_q <= 1'b0;
        end else begin
            wr_act_q <= wr_act;
            rdflag_q <= rd_act;
            wrflg_q  <= wr_done;
            // Shadow follows the bus every active edge; last sample wins
            if (wr_act) begin
                sh_d_q  <= D;
                sh_a0_q <= A0;
            end
            if (wr_done) begin
                wr_q    <= sh_d_q;
                b0_q    <= sh_a0_q;
                cadr_q  <= code;
                state_q <= state_d;
                sngl_q  <= sngl_d;
                ic4_q   <= ic4_d;
            end
        end
    end

    assign WR     = wr_q;
    assign cadr   = cadr_q;
    assign b0     = b0_q;
    assign wrflg  = wrflg_q;
    assign rdflag = rdflag_q;

endmodule

// File: tb/tb_pic_rw_ctrl_buffer.sv
module tb_pic_rw_ctrl_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       CSn = 1'b1, rdn = 1'b1, wrn = 1'b1, A0 = 1'b0;
    logic [7:0] PCadr = 8'h00;
    logic       en = 1'b0, ino = 1'b0;
    logic [7:0] tb_d = 8'h00;
    logic       tb_drv = 1'b0;
    wire  [7:0] D;
    logic [7:0] WR;
    logic [2:0] cadr;
    logic       b0, wrflg, rdflag;

    int checks = 0;
    int errors = 0;

    assign D = tb_drv ? tb_d : 8'hzz;

    always #5 clk = ~clk;

    pic_rw_ctrl_buffer dut (
        .clk(clk), .rst_n(rst_n), .CSn(CSn), .rdn(rdn), .wrn(wrn), .A0(A0),
        .D(D), .PCadr(PCadr), .en(en), .ino(ino), .WR(WR), .cadr(cadr),
        .b0(b0), .wrflg(wrflg), .rdflag(rdflag)
    );

`ifdef PIC_RW_ICW4_EN
    localparam bit ICW4_ON = 1'b1;
`else
    localparam bit ICW4_ON = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // step: the next init word expected (1..4), 5 once initialised
    int         m_step;
    bit         m_sngl, m_ic4;
    logic [7:0] m_wr;
    int         m_cadr;
    bit         m_b0, m_wrflg, m_rd;

    function automatic int classify(input bit a0, input logic [7:0] d);
        int c, nxt;
        bit found;
        if (!a0 && d[4]) begin
            m_sngl = d[1];
            m_ic4  = ICW4_ON ? d[0] : 1'b0;
            m_step = 2;
            return 1;
        end
        if (a0 && m_step >= 2 && m_step <= 4) begin
            c = m_step;
            nxt = 5;
            found = 1'b0;
            for (int s = c + 1; s <= 4; s++)
                if (!found && !(s == 3 && m_sngl) && !(s == 4 && !m_ic4)) begin
                    nxt = s;
                    found = 1'b1;
                end
            m_step = nxt;
            return c;
        end
        if (m_step == 5) begin
            if (a0)             return 5;
            if (d[4:3] == 2'd0) return 6;
            if (d[4:3] == 2'd1) return 7;
        end
        return 0;
    endfunction

    initial begin : cmp
        bit         prev_wa, wa, ra;
        logic [7:0] sd;
        bit         sa;
        prev_wa = 0; sd = 0; sa = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                prev_wa = 0; sd = 0; sa = 0;
                m_step = 1; m_sngl = 0; m_ic4 = 0;
                m_wr = 0; m_cadr = 0; m_b0 = 0; m_wrflg = 0; m_rd = 0;
            end else begin
                wa = !CSn && !wrn && rdn;
                ra = !CSn && !rdn && wrn;
                m_wrflg = 0;
                if (prev_wa && !wa) begin
                    m_wr    = sd;
                    m_b0    = sa;
                    m_cadr  = classify(sa, sd);
                    m_wrflg = 1;
                end
                if (wa) begin sd = D; sa = A0; end
                prev_wa = wa;
                m_rd    = ra;
            end
            #1;
            chk("m_WR", WR, m_wr);
            chk("m_cadr", cadr, m_cadr);
            chk("m_b0", b0, m_b0);
            chk("m_wrflg", wrflg, m_wrflg);
            chk("m_rdflag", rdflag, m_rd);
        end
    end

    // ---------------- directed stimulus ----------------
    // Hold the write active for 'hold' sampled edges, release, then check
    // the completion cycle against hand-computed values.
    task automatic do_write(input bit a0, input logic [7:0] d, input int hold,
                            input int exp_cadr);
        @(negedge clk);
        CSn = 0; wrn = 0; A0 = a0; tb_d = d; tb_drv = 1;
        repeat (hold) @(negedge clk);
        CSn = 1; wrn = 1; tb_drv = 0;
        @(posedge clk); #1;
        chk("wr_flag", wrflg, 1);
        chk("wr_cadr", cadr, exp_cadr);
        chk("wr_data", WR, d);
        chk("wr_b0", b0, a0);
        @(negedge clk);
    endtask

    initial begin : stim
        int cnt_r, cnt_w;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_WR", WR, 0);
        chk("rst_cadr", cadr, 0);
        chk("rst_wrflg", wrflg, 0);
        chk("rst_rdflag", rdflag, 0);
        rst_n = 1;

        // buffer
        en = 1; ino = 1; PCadr = 8'hAA; #1;
        chk("buf_drive", D, 8'hAA);
        en = 0; tb_drv = 1; tb_d = 8'h55; #1;
        chk("buf_off_en", D, 8'h55);
        en = 1; ino = 0; #1;
        chk("buf_off_ino", D, 8'h55);
        en = 0; tb_drv = 0;

        // ignored write from WAIT_ICW1
        do_write(1, 8'h55, 1, 0);

        // single mode with IC4
        do_write(0, 8'h13, 1, 1);
        do_write(1, 8'h08, 2, 2);
        do_write(1, 8'h01, 1, ICW4_ON ? 4 : 5);

        // cascade init without IC4, then OCWs
        do_write(0, 8'h10, 1, 1);
        do_write(1, 8'h20, 3, 2);
        do_write(1, 8'h04, 1, 3);
        do_write(1, 8'hFE, 1, 5);
        do_write(0, 8'h20, 1, 6);
        do_write(0, 8'h0B, 2, 7);

        // ignored write mid-sequence, then continue
        do_write(0, 8'h12, 1, 1);
        do_write(0, 8'h00, 1, 0);
        do_write(1, 8'h40, 1, 2);
        do_write(1, 8'h33, 1, 5);

        // read cycle: three active samples
        @(negedge clk);
        CSn = 0; rdn = 0;
        cnt_r = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("rd_lag", rdflag, 1);
            if (rdflag) cnt_r++;
            if (i == 2) begin @(negedge clk); CSn = 1; rdn = 1; end
        end
        chk("rd_count", cnt_r, 3);

        // conflict with CSn high: nothing happens
        @(negedge clk);
        CSn = 1; rdn = 0; wrn = 0;
        cnt_r = 0; cnt_w = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rdflag) cnt_r++;
            if (wrflg) cnt_w++;
        end
        chk("cfl_rd", cnt_r, 0);
        chk("cfl_wr", cnt_w, 0);
        @(negedge clk);
        rdn = 1; wrn = 1;

        // write ended by rdn dropping (both strobes low)
        @(negedge clk);
        CSn = 0; wrn = 0; A0 = 1; tb_d = 8'h77; tb_drv = 1;
        repeat (2) @(negedge clk);
        rdn = 0;
        @(posedge clk); #1;
        chk("rdn_end_flag", wrflg, 1);
        chk("rdn_end_cadr", cadr, 5);
        chk("rdn_end_WR", WR, 8'h77);
        @(negedge clk);
        CSn = 1; rdn = 1; wrn = 1; tb_drv = 0;
        @(negedge clk);

        // reset mid-write
        @(negedge clk);
        CSn = 0; wrn = 0; A0 = 0; tb_d = 8'h1F; tb_drv = 1;
        repeat (2) @(negedge clk);
        rst_n = 0; #1;
        chk("mrst_WR", WR, 0);
        chk("mrst_cadr", cadr, 0);
        chk("mrst_b0", b0, 0);
        repeat (2) @(negedge clk);
        CSn = 1; wrn = 1; tb_drv = 0;
        @(negedge clk);
        rst_n = 1;
        cnt_w = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (wrflg) cnt_w++;
        end
        chk("mrst_noflag", cnt_w, 0);

        // state returned to WAIT_ICW1
        do_write(1, 8'h55, 1, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
